eth_crc32_insert: RTL and testbench
===================================

ETH_CRC32_INSERT -- requirements
Module: eth_crc32_insert

Interface
REQ-001 Parameter DATA_BYTES, default 4, bytes per beat; legal values 1, 2, 4, 8.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_data  input  8*DATA_BYTES  input frame bytes; lane 0 (bits 7:0) is earliest on wire.
REQ-005 s_keep  input  DATA_BYTES  byte valid mask, contiguous from lane 0.
REQ-006 s_valid / s_last  input  1 each  beat valid / final beat of frame.
REQ-007 s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-008 m_data / m_keep  output  8*DATA_BYTES / DATA_BYTES  frame with FCS appended, same lane order.
REQ-009 m_valid / m_last  output  1 each  output beat valid / final beat (includes FCS).
REQ-010 m_ready  input  1  output beat consumed when m_valid && m_ready.
REQ-011 crc_value  output  32  FCS of most recent completed frame.
REQ-012 crc_done  output  1  one-cycle pulse when crc_value updates.

Function
REQ-013 CRC SHALL be Ethernet CRC-32: poly 0x04C11DB7, reflected in/out, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-014 Running CRC register SHALL update on each accepted input beat over exactly the bytes flagged by s_keep, all bytes of a beat in one cycle, lane 0 first.
REQ-015 s_keep SHALL be treated as all-ones on non-last beats; on last beat it gives n = valid bytes (0..DATA_BYTES).
REQ-016 Running CRC SHALL re-initialise to 0xFFFFFFFF in the cycle after the last beat is accepted; back-to-back frames need no idle cycle.
REQ-017 FCS byte order SHALL be crc[7:0], crc[15:8], crc[23:16], crc[31:24] (first to last on wire).
REQ-018 Output SHALL be registered: accepted input beat appears on m_* the next cycle; no padding, no byte modification.
REQ-019 States: IDLE/DATA (passing beats) and FCS (emitting leftover FCS bytes); reset enters DATA with no frame in progress.
REQ-020 Last beat with n+4 <= DATA_BYTES: FCS in lanes n..n+3, m_keep = n+4 ones, m_last=1 on that beat, stay DATA.
REQ-021 Last beat with n+4 > DATA_BYTES: lanes n..DATA_BYTES-1 carry first FCS bytes, m_last=0; go FCS; emit remaining bytes in ceil((n+4)/DATA_BYTES)-1 further beats, lanes from 0, m_last on final one; then DATA.
REQ-022 s_ready SHALL be (!m_valid || m_ready) in DATA and 0 in FCS state.
REQ-023 While m_valid && !m_ready, m_data, m_keep, m_last SHALL hold stable.
REQ-024 Unused m_data lanes (m_keep=0) SHALL be driven 0.
REQ-025 crc_value SHALL load the final FCS and crc_done pulse in the cycle after the last input beat is accepted; crc_value holds otherwise.

Reset
REQ-026 On reset: m_valid=0, m_data=0, m_keep=0, m_last=0, crc_done=0, crc_value=0, running CRC=0xFFFFFFFF, state DATA, s_ready=1 in the following cycle.
REQ-027 Reset mid-frame or mid-FCS SHALL discard the partial frame and pending output; next accepted beat starts a new frame.

Verification
REQ-028 DATA_BYTES=1, "123456789" (0x31..0x39), m_ready=1 -> 13 output beats, last four 0x26,0x39,0xF4,0xCB, m_last on 13th, crc_value=0xCBF43926, one crc_done pulse.
REQ-029 DATA_BYTES=4, same bytes as beats keep 0xF,0xF,0x1(last) -> beat 3 keep 0xF lanes1-3 = 26 39 F4, m_last=0; beat 4 keep 0x1 lane0 = CB, m_last=1; s_ready=0 for one cycle.
REQ-030 DATA_BYTES=8, beats keep 0xFF, 0x01(last) -> beat 2 keep 0x1F, lanes1-4 = 26 39 F4 CB, m_last=1, no extra beat.
REQ-031 DATA_BYTES=4, REQ-029 stimulus with random m_ready and s_valid gaps -> identical output byte stream, outputs stable under stall, no beat lost or duplicated.
REQ-032 DATA_BYTES=4, two REQ-029 frames back-to-back, reset pulsed one cycle after first beat of frame 1 -> frame 1 discarded, m_valid=0 after reset, frame 2 output correct, crc_value=0xCBF43926.

Source files
------------

// File: rtl/eth_crc32_insert.sv
// Ethernet FCS inserter: passes frame beats through one register stage, computes the
// reflected CRC-32 of each frame and appends the 4-byte FCS after the last data byte,
// spilling into extra beats when the last beat has no room for it.
module eth_crc32_insert #(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [DATA_BYTES-1:0]   m_keep,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [31:0]             crc_value,
  output logic                    crc_done
);

  localparam int unsigned DataW   = 8 * DATA_BYTES;
  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;  // 0x04C11DB7 bit-reversed

  typedef enum logic [0:0] {StData, StFcs} state_e;

  state_e              state_q;
  logic [31:0]         crc_q;
  logic [31:0]         fcs_q;
  logic [2:0]          fcs_sent_q;  // FCS bytes already emitted for the pending frame
  logic [DataW-1:0]    m_data_q;
  logic [DATA_BYTES-1:0] m_keep_q;
  logic                m_valid_q;
  logic                m_last_q;

  // One byte of the LSB-first CRC-32.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  logic slot_free;
  logic accept;

  assign slot_free = !m_valid_q || m_ready;
  assign s_ready   = (state_q == StData) && slot_free;
  assign accept    = s_valid && s_ready;

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

  logic [DATA_BYTES-1:0] keep_eff;
  logic [3:0]            n_bytes;
  logic [31:0]           crc_next;
  logic [31:0]           fcs_next;

  // Fold the valid bytes of the input beat into the running CRC, lane 0 first.
  always_comb begin
    keep_eff = s_last ? s_keep : '1;
    n_bytes  = '0;
    crc_next = crc_q;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      if (keep_eff[i]) begin
        n_bytes  = n_bytes + 4'd1;
        crc_next = crc_byte(crc_next, s_data[8*i +: 8]);
      end
    end
    fcs_next = ~crc_next;
  end

  logic [DataW-1:0]      beat_data;
  logic [DATA_BYTES-1:0] beat_keep;
  logic                  beat_last;
  logic                  beat_fcs_left;
  logic [2:0]            beat_sent;
  logic [31:0]           beat_tmp;

  // Output beat for an accepted input beat; on the last beat the FCS follows the data lanes.
  always_comb begin
    beat_data     = '0;
    beat_keep     = '0;
    beat_last     = 1'b0;
    beat_fcs_left = 1'b0;
    beat_sent     = '0;
    beat_tmp      = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      if (i < int'(n_bytes)) begin
        beat_data[8*i +: 8] = s_data[8*i +: 8];
        beat_keep[i]        = 1'b1;
      end else if (s_last && (i < int'(n_bytes) + 4)) begin
        beat_tmp            = fcs_next >> (8 * (i - int'(n_bytes)));
        beat_data[8*i +: 8] = beat_tmp[7:0];
        beat_keep[i]        = 1'b1;
      end
    end
    if (s_last) begin
      if (int'(n_bytes) + 4 <= int'(DATA_BYTES)) begin
        beat_last = 1'b1;
      end else begin
        beat_fcs_left = 1'b1;
        beat_sent     = 3'(int'(DATA_BYTES) - int'(n_bytes));
      end
    end
  end

  logic [DataW-1:0]      fcs_data;
  logic [DATA_BYTES-1:0] fcs_keep;
  logic [2:0]            fcs_sent_next;
  logic                  fcs_done;
  logic [31:0]           fcs_tmp;

  // Leftover FCS bytes packed from lane 0.
  always_comb begin
    fcs_data      = '0;
    fcs_keep      = '0;
    fcs_sent_next = fcs_sent_q;
    fcs_tmp       = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      if (int'(fcs_sent_q) + i < 4) begin
        fcs_tmp            = fcs_q >> (8 * (int'(fcs_sent_q) + i));
        fcs_data[8*i +: 8] = fcs_tmp[7:0];
        fcs_keep[i]        = 1'b1;
        fcs_sent_next      = fcs_sent_next + 3'd1;
      end
    end
    fcs_done = (fcs_sent_next == 3'd4);
  end

  // FSM, running CRC, result register and output pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StData;
      crc_q      <= CrcInit;
      fcs_q      <= '0;
      fcs_sent_q <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      crc_value  <= '0;
      crc_done   <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      if (accept) begin
        crc_q <= s_last ? CrcInit : crc_next;
        if (s_last) begin
          crc_value <= fcs_next;
          crc_done  <= 1'b1;
        end
      end
      // Stalled output (valid without ready) holds every m_* field.
      if (slot_free) begin
        if (state_q == StFcs) begin
          m_valid_q  <= 1'b1;
          m_data_q   <= fcs_data;
          m_keep_q   <= fcs_keep;
          m_last_q   <= fcs_done;
          fcs_sent_q <= fcs_sent_next;
          if (fcs_done) begin
            state_q <= StData;
          end
        end else if (s_valid) begin
          m_valid_q <= 1'b1;
          m_data_q  <= beat_data;
          m_keep_q  <= beat_keep;
          m_last_q  <= beat_last;
          if (beat_fcs_left) begin
            state_q    <= StFcs;
            fcs_q      <= fcs_next;
            fcs_sent_q <= beat_sent;
          end
        end else begin
          m_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_crc32_insert.sv
// Bench for eth_crc32_insert: three instances (1, 4 and 8 bytes per beat) fed the
// "123456789" frame; expected output beats are queued when stimulus is driven and
// compared as the DUTs hand beats over.
module tb_eth_crc32_insert;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0]  s1_data;  logic [0:0] s1_keep;  logic s1_valid, s1_last, s1_ready;
  logic [7:0]  m1_data;  logic [0:0] m1_keep;  logic m1_valid, m1_last;
  logic        m1_ready = 1'b1;
  logic [31:0] crc1;     logic done1;

  logic [31:0] s4_data;  logic [3:0] s4_keep;  logic s4_valid, s4_last, s4_ready;
  logic [31:0] m4_data;  logic [3:0] m4_keep;  logic m4_valid, m4_last;
  logic        m4_ready = 1'b1;
  logic [31:0] crc4;     logic done4;

  logic [63:0] s8_data;  logic [7:0] s8_keep;  logic s8_valid, s8_last, s8_ready;
  logic [63:0] m8_data;  logic [7:0] m8_keep;  logic m8_valid, m8_last;
  logic        m8_ready = 1'b1;
  logic [31:0] crc8;     logic done8;

  eth_crc32_insert #(.DATA_BYTES(1)) u_dut1 (
    .clk(clk), .reset(rst),
    .s_data(s1_data), .s_keep(s1_keep), .s_valid(s1_valid), .s_last(s1_last),
    .s_ready(s1_ready),
    .m_data(m1_data), .m_keep(m1_keep), .m_valid(m1_valid), .m_last(m1_last),
    .m_ready(m1_ready), .crc_value(crc1), .crc_done(done1)
  );

  eth_crc32_insert #(.DATA_BYTES(4)) u_dut4 (
    .clk(clk), .reset(rst),
    .s_data(s4_data), .s_keep(s4_keep), .s_valid(s4_valid), .s_last(s4_last),
    .s_ready(s4_ready),
    .m_data(m4_data), .m_keep(m4_keep), .m_valid(m4_valid), .m_last(m4_last),
    .m_ready(m4_ready), .crc_value(crc4), .crc_done(done4)
  );

  eth_crc32_insert #(.DATA_BYTES(8)) u_dut8 (
    .clk(clk), .reset(rst),
    .s_data(s8_data), .s_keep(s8_keep), .s_valid(s8_valid), .s_last(s8_last),
    .s_ready(s8_ready),
    .m_data(m8_data), .m_keep(m8_keep), .m_valid(m8_valid), .m_last(m8_last),
    .m_ready(m8_ready), .crc_value(crc8), .crc_done(done8)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t q1[$];
  beat_t q4[$];
  beat_t q8[$];
  beat_t b1, b4, b8;

  int n_cmp = 0;
  int n_bad = 0;
  int idx1 = 0, idx4 = 0, idx8 = 0;
  int done_cnt1 = 0, done_cnt4 = 0, done_cnt8 = 0;
  int mode1 = 0, mode4 = 0, mode8 = 0;  // 0: ready high, 1: random, 2: ready low
  logic win4 = 1'b0;
  int lo4 = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    #1;
    m1_ready = rdy(mode1);
    m4_ready = rdy(mode4);
    m8_ready = rdy(mode8);
  end

  // Scoreboards: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (m1_valid && m1_ready) begin
      if (q1.size() == 0) check("d1_extra_beat", 1, 0);
      else begin
        b1 = q1.pop_front();
        check($sformatf("d1_data%0d", idx1), m1_data, b1.data[7:0]);
        check($sformatf("d1_keep%0d", idx1), m1_keep, b1.keep[0:0]);
        check($sformatf("d1_last%0d", idx1), m1_last, b1.last);
      end
      idx1++;
    end
    if (m4_valid && m4_ready) begin
      if (q4.size() == 0) check("d4_extra_beat", 1, 0);
      else begin
        b4 = q4.pop_front();
        check($sformatf("d4_data%0d", idx4), m4_data, b4.data[31:0]);
        check($sformatf("d4_keep%0d", idx4), m4_keep, b4.keep[3:0]);
        check($sformatf("d4_last%0d", idx4), m4_last, b4.last);
      end
      idx4++;
    end
    if (m8_valid && m8_ready) begin
      if (q8.size() == 0) check("d8_extra_beat", 1, 0);
      else begin
        b8 = q8.pop_front();
        check($sformatf("d8_data%0d", idx8), m8_data, b8.data);
        check($sformatf("d8_keep%0d", idx8), m8_keep, b8.keep);
        check($sformatf("d8_last%0d", idx8), m8_last, b8.last);
      end
      idx8++;
    end
    if (done1) done_cnt1++;
    if (done4) done_cnt4++;
    if (done8) done_cnt8++;
    if (win4 && !s4_ready) lo4++;
  end

  task automatic push(input int dut, input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    case (dut)
      1:       q1.push_back(b);
      4:       q4.push_back(b);
      default: q8.push_back(b);
    endcase
  endtask

  // Drive one beat and hold it until accepted; entered and left at posedge+1.
  task automatic send(input int dut, input logic [63:0] d, input logic [7:0] k, input logic l,
                      input int gap);
    logic acc;
    int   cyc;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    case (dut)
      1: begin s1_data = d[7:0]; s1_keep = k[0:0]; s1_last = l; s1_valid = 1'b1; end
      4: begin s4_data = d[31:0]; s4_keep = k[3:0]; s4_last = l; s4_valid = 1'b1; end
      default: begin s8_data = d; s8_keep = k; s8_last = l; s8_valid = 1'b1; end
    endcase
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 200) begin
      @(negedge clk);
      case (dut)
        1:       acc = s1_ready;
        4:       acc = s4_ready;
        default: acc = s8_ready;
      endcase
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) check($sformatf("d%0d_accept_timeout", dut), 0, 1);
    s1_valid = 1'b0; s4_valid = 1'b0; s8_valid = 1'b0;
  endtask

  task automatic expect_frame4();
    push(4, 64'h3433_3231, 8'h0F, 1'b0);
    push(4, 64'h3837_3635, 8'h0F, 1'b0);
    push(4, 64'hF439_2639, 8'h0F, 1'b0);
    push(4, 64'h0000_00CB, 8'h01, 1'b1);
  endtask

  task automatic frame4(input int gap_max);
    send(4, 64'h3433_3231, 8'h0F, 1'b0, $urandom_range(0, gap_max));
    send(4, 64'h3837_3635, 8'h0F, 1'b0, $urandom_range(0, gap_max));
    send(4, 64'h0000_0039, 8'h01, 1'b1, $urandom_range(0, gap_max));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((q1.size() + q4.size() + q8.size()) != 0 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_q1", q1.size(), 0);
    check("drain_q4", q4.size(), 0);
    check("drain_q8", q8.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    s1_data = '0; s1_keep = '0; s1_valid = 1'b0; s1_last = 1'b0;
    s4_data = '0; s4_keep = '0; s4_valid = 1'b0; s4_last = 1'b0;
    s8_data = '0; s8_keep = '0; s8_valid = 1'b0; s8_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_m_valid", {m1_valid, m4_valid, m8_valid}, 3'b000);
    check("rst_m_last", {m1_last, m4_last, m8_last}, 3'b000);
    check("rst_m_keep", {m1_keep, m4_keep, m8_keep}, 13'h0);
    check("rst_m_data4", m4_data, 32'h0);
    check("rst_m_data8", m8_data, 64'h0);
    check("rst_crc_value", {crc1, crc4, crc8}, 96'h0);
    check("rst_crc_done", {done1, done4, done8}, 3'b000);
    check("rst_s_ready", {s1_ready, s4_ready, s8_ready}, 3'b111);
    @(posedge clk);
    #1;

    // One byte per beat: FCS needs four extra beats.
    for (int i = 0; i < 9; i++) push(1, 64'(8'h31 + i), 8'h01, 1'b0);
    push(1, 64'h26, 8'h01, 1'b0);
    push(1, 64'h39, 8'h01, 1'b0);
    push(1, 64'hF4, 8'h01, 1'b0);
    push(1, 64'hCB, 8'h01, 1'b1);
    for (int i = 0; i < 9; i++) send(1, 64'(8'h31 + i), 8'h01, (i == 8), 0);
    drain();
    check("d1_crc_value", crc1, 32'hCBF4_3926);
    check("d1_crc_done_cnt", done_cnt1, 1);

    // Four bytes per beat: FCS straddles the last beat, one stall cycle on s_ready.
    win4 = 1'b1;
    expect_frame4();
    frame4(0);
    drain();
    win4 = 1'b0;
    check("d4_s_ready_low_cycles", lo4, 1);
    check("d4_crc_value", crc4, 32'hCBF4_3926);
    check("d4_crc_done_cnt", done_cnt4, 1);

    // Eight bytes per beat: FCS fits in the last beat.
    push(8, 64'h3837_3635_3433_3231, 8'hFF, 1'b0);
    push(8, 64'h0000_00CB_F439_2639, 8'h1F, 1'b1);
    send(8, 64'h3837_3635_3433_3231, 8'hFF, 1'b0, 0);
    send(8, 64'h0000_0000_0000_0039, 8'h01, 1'b1, 0);
    drain();
    check("d8_crc_value", crc8, 32'hCBF4_3926);
    check("d8_crc_done_cnt", done_cnt8, 1);

    // Random backpressure and input gaps, two frames.
    mode4 = 1;
    expect_frame4();
    expect_frame4();
    frame4(3);
    frame4(3);
    drain();
    mode4 = 0;
    check("d4_rand_crc_value", crc4, 32'hCBF4_3926);
    check("d4_rand_crc_done_cnt", done_cnt4, 3);

    // Reset one cycle after the first beat of a frame discards it.
    mode4 = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send(4, 64'h3433_3231, 8'h0F, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode4 = 0;
    @(negedge clk);
    check("d4_midrst_m_valid", m4_valid, 1'b0);
    check("d4_midrst_s_ready", s4_ready, 1'b1);
    check("d4_midrst_crc_value", crc4, 32'h0);
    @(posedge clk);
    #1;
    expect_frame4();
    frame4(0);
    drain();
    check("d4_post_rst_crc_value", crc4, 32'hCBF4_3926);
    check("d4_post_rst_crc_done_cnt", done_cnt4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
